// File: rtl/tick_gen_multi_pkg.sv
// Shared constants and elaboration helpers for the multi-channel timebase.
package tick_pkg;

    localparam int unsigned SEL_W       = 4;
    localparam int unsigned PARK_PERIOD = 0;

    // Prescaler divide ratio; a zero base rate yields 0 so the top can flag it.
    function automatic int unsigned pre_div(input int unsigned clk_hz, input int unsigned base_hz);
        return (base_hz == 0) ? 0 : clk_hz / base_hz;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_gen_multi_if.sv
// Control/status bundle between a timebase user and tick_gen_multi.
interface tick_gen_multi_if
    import tick_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned PW  = 16
) ();

    logic [NCH-1:0]   en;
    logic             cfg_we;
    logic [SEL_W-1:0] cfg_sel;
    logic [PW-1:0]    cfg_period;
    logic [NCH-1:0]   cfg_pend;
    logic             base_tick;
    logic [NCH-1:0]   tick_o;
    logic [NCH-1:0]   sq_o;

    modport master (
        output en, cfg_we, cfg_sel, cfg_period,
        input  cfg_pend, base_tick, tick_o, sq_o
    );

    modport slave (
        input  en, cfg_we, cfg_sel, cfg_period,
        output cfg_pend, base_tick, tick_o, sq_o
    );

endinterface

// File: rtl/tick_gen_multi_chan.sv
// One timebase channel: counts base ticks, pulses at wrap, drives a square wave,
// and defers period updates to the next wrap through a shadow register.
module tick_chan
    import tick_pkg::*;
#(
    parameter int unsigned PW         = 16,
    parameter int unsigned DEF_PERIOD = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          base_tick,
    input  logic          en,
    input  logic          clr,
    input  logic          wr,
    input  logic [PW-1:0] wdata,
    output logic          tick,
    output logic          sq,
    output logic          pend
);

    localparam logic [PW-1:0] PER_RST  = PW'(DEF_PERIOD);
    localparam logic [PW-1:0] PER_PARK = PW'(PARK_PERIOD);

    logic [PW-1:0] cnt;
    logic [PW-1:0] per;
    logic [PW-1:0] shadow;
    logic          step_c;
    logic          parked_c;
    logic          wrap_c;
    logic          sq_fall_c;

    // Decode of the current count against the active period.
    always_comb begin
        step_c    = base_tick && en;
        parked_c  = (per == PER_PARK);
        wrap_c    = (cnt == per - PW'(1));
        sq_fall_c = (per >= PW'(2)) && (cnt == (per >> 1) - PW'(1));
    end

    // Count, tick, square wave and shadow/pending period state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            per    <= PER_RST;
            shadow <= PER_RST;
            pend   <= 1'b0;
            tick   <= 1'b0;
            sq     <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
            sq   <= 1'b0;
            pend <= 1'b0;
            if (pend) begin
                per <= shadow;
            end
        end else begin
            tick <= 1'b0;
            if (step_c) begin
                if (parked_c) begin
                    // Parked channel has no wrap: take a pending period right away.
                    cnt <= '0;
                    sq  <= 1'b0;
                    if (pend) begin
                        per  <= shadow;
                        pend <= 1'b0;
                    end
                end else if (wrap_c) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    sq   <= (per == PW'(1)) ? ~sq : 1'b1;
                    if (pend) begin
                        per  <= shadow;
                        pend <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + PW'(1);
                    if (sq_fall_c) begin
                        sq <= 1'b0;
                    end
                end
            end
            // A write lands after any wrap load in the same cycle, re-arming pend.
            if (wr) begin
                shadow <= wdata;
                pend   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel timebase: shared prescaler plus NCH programmable tick channels.
module tick_gen_multi
    import tick_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BASE_HZ    = 1_000,
    parameter int unsigned NCH        = 4,
    parameter int unsigned PW         = 16,
    parameter int unsigned DEF_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_clr,
    tick_gen_multi_if.slave  bus
);

    localparam int unsigned PRE_DIV = pre_div(CLK_HZ, BASE_HZ);
    localparam int unsigned PRE_W   = cnt_w(PRE_DIV);

    // Reject configurations the prescaler or channel select cannot support.
    if (PRE_DIV < 2) begin : g_bad_div
        $error("tick_gen_multi: CLK_HZ/BASE_HZ must be at least 2");
    end
    if (NCH < 1 || NCH > 16) begin : g_bad_nch
        $error("tick_gen_multi: NCH must be 1..16");
    end

    logic [PRE_W-1:0] pre_cnt;
    logic             base_tick;
    logic             pre_tc_c;
    logic [NCH-1:0]   wr_c;
    logic [NCH-1:0]   tick_w;
    logic [NCH-1:0]   sq_w;
    logic [NCH-1:0]   pend_w;

    // Prescaler terminal count and write-strobe decode.
    always_comb begin
        pre_tc_c = (pre_cnt == PRE_W'(PRE_DIV - 1));
        wr_c     = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_c[i] = bus.cfg_we && (bus.cfg_sel == SEL_W'(i));
        end
    end

    // Prescaler: base_tick is registered one cycle after the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            base_tick <= 1'b0;
        end else if (sync_clr) begin
            pre_cnt   <= '0;
            base_tick <= 1'b0;
        end else begin
            base_tick <= pre_tc_c;
            pre_cnt   <= pre_tc_c ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tick_chan #(
            .PW         (PW),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .base_tick  (base_tick),
            .en         (bus.en[i]),
            .clr        (sync_clr),
            .wr         (wr_c[i]),
            .wdata      (bus.cfg_period),
            .tick       (tick_w[i]),
            .sq         (sq_w[i]),
            .pend       (pend_w[i])
        );
    end

    assign bus.base_tick = base_tick;
    assign bus.tick_o    = tick_w;
    assign bus.sq_o      = sq_w;
    assign bus.cfg_pend  = pend_w;

endmodule

// File: tb/tb_tick_gen_multi.sv
// Bench for tick_gen_multi at PRE_DIV=10, NCH=4, PW=8, DEF_PERIOD=10.
module tb_tick_gen_multi;

    localparam int NCH = 4;

    logic clk;
    logic rst_n;
    logic sync_clr;
    int   cyc;
    int   total;
    int   bad;
    int   exp_q[NCH][$];

    tick_gen_multi_if #(.NCH(4), .PW(8)) bus ();

    tick_gen_multi #(
        .CLK_HZ     (100),
        .BASE_HZ    (10),
        .NCH        (4),
        .PW         (8),
        .DEF_PERIOD (10)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_clr (sync_clr),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clock edges since the last reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct packed {
        int       cyc;
        bit       base;
        bit [3:0] sq;
        bit [3:0] sqm;
        bit [3:0] pend;
        bit       we;
        bit [3:0] sel;
        bit [7:0] per;
        bit [3:0] en;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(int c, bit b, bit [3:0] s, bit [3:0] m, bit [3:0] p,
                               bit w, bit [3:0] sl, bit [7:0] pr, bit [3:0] e);
        vec_t r;
        r.cyc = c; r.base = b; r.sq = s; r.sqm = m; r.pend = p;
        r.we = w; r.sel = sl; r.per = pr; r.en = e;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, want);
        end
    endtask

    // Advance one clock and score tick pulses against the expected-tick queues.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            while (exp_q[i].size() > 0 && exp_q[i][0] < cyc) begin
                total++;
                bad++;
                $display("FAIL tick%0d missing: got none want pulse at cyc %0d", i, exp_q[i][0]);
                void'(exp_q[i].pop_front());
            end
            if (bus.tick_o[i]) begin
                total++;
                if (exp_q[i].size() == 0 || exp_q[i][0] != cyc) begin
                    bad++;
                    $display("FAIL tick%0d unexpected: got pulse at cyc %0d want none", i, cyc);
                end else begin
                    void'(exp_q[i].pop_front());
                end
            end
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic drive(input bit we, input bit [3:0] sel, input bit [7:0] per);
        bus.cfg_we     = we;
        bus.cfg_sel    = sel;
        bus.cfg_period = per;
    endtask

    task automatic chk_drained(input string nm);
        for (int i = 0; i < NCH; i++) chk($sformatf("%s_q%0d", nm, i), 32'(exp_q[i].size()), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        sync_clr = 1'b0;
        bus.en = 4'hF;
        drive(1'b0, 4'd0, 8'd0);

        // Vectors: check at cycle, then drive inputs for the next edge.
        tbl.push_back(v(  9, 0, 4'h0, 4'hF, 4'h0, 0, 0, 0, 4'hF));
        tbl.push_back(v( 10, 1, 4'h0, 4'hF, 4'h0, 0, 0, 0, 4'hF));
        tbl.push_back(v( 11, 0, 4'h0, 4'hF, 4'h0, 0, 0, 0, 4'hF));
        tbl.push_back(v(100, 1, 4'h0, 4'hF, 4'h0, 0, 0, 0, 4'hF));
        tbl.push_back(v(101, 0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 4'hF));
        tbl.push_back(v(150, 1, 4'hF, 4'hF, 4'h0, 0, 0, 0, 4'hF));
        tbl.push_back(v(151, 0, 4'h0, 4'hF, 4'h0, 0, 0, 0, 4'hF));
        tbl.push_back(v(201, 0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 4'hF));
        tbl.push_back(v(230, 1, 4'hF, 4'hF, 4'h0, 1, 1, 3, 4'hF));
        tbl.push_back(v(231, 0, 4'hF, 4'hF, 4'h2, 0, 0, 0, 4'hF));
        tbl.push_back(v(300, 1, 4'h0, 4'hF, 4'h2, 0, 0, 0, 4'hF));
        tbl.push_back(v(301, 0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 4'hF));
        tbl.push_back(v(310, 1, 4'hF, 4'hF, 4'h0, 1, 2, 0, 4'hF));
        tbl.push_back(v(311, 0, 4'hD, 4'hF, 4'h4, 0, 0, 0, 4'hF));
        tbl.push_back(v(321, 0, 4'h0, 4'h2, 4'h4, 0, 0, 0, 4'hF));
        tbl.push_back(v(331, 0, 4'h2, 4'h2, 4'h4, 0, 0, 0, 4'hF));
        tbl.push_back(v(401, 0, 4'hD, 4'hF, 4'h0, 0, 0, 0, 4'hF));
        // en[0] low for edges 423..457: three base ticks are swallowed.
        tbl.push_back(v(422, 0, 4'h1, 4'h1, 4'h0, 0, 0, 0, 4'hE));
        tbl.push_back(v(450, 1, 4'h1, 4'h5, 4'h0, 1, 2, 1, 4'hE));
        tbl.push_back(v(451, 0, 4'h1, 4'h5, 4'h4, 0, 0, 0, 4'hE));
        tbl.push_back(v(457, 0, 4'h1, 4'h1, 4'h4, 0, 0, 0, 4'hF));
        tbl.push_back(v(461, 0, 4'h1, 4'h5, 4'h0, 0, 0, 0, 4'hF));
        tbl.push_back(v(471, 0, 4'h5, 4'h5, 4'h0, 0, 0, 0, 4'hF));
        tbl.push_back(v(481, 0, 4'h0, 4'h5, 4'h0, 0, 0, 0, 4'hF));
        tbl.push_back(v(491, 0, 4'h4, 4'h5, 4'h0, 0, 0, 0, 4'hF));

        // Expected tick cycles up to the reset at cycle 710.
        for (int c = 101; c <= 401; c += 100) exp_q[0].push_back(c);
        exp_q[0].push_back(531);
        exp_q[0].push_back(671);
        exp_q[1].push_back(101);
        exp_q[1].push_back(201);
        for (int c = 301; c <= 541; c += 30) exp_q[1].push_back(c);
        for (int c = 601; c <= 691; c += 30) exp_q[1].push_back(c);
        for (int c = 101; c <= 401; c += 100) exp_q[2].push_back(c);
        for (int c = 471; c <= 561; c += 10) exp_q[2].push_back(c);
        for (int c = 581; c <= 701; c += 10) exp_q[2].push_back(c);
        for (int c = 101; c <= 501; c += 100) exp_q[3].push_back(c);
        exp_q[3].push_back(621);
        exp_q[3].push_back(671);

        repeat (3) @(negedge clk);
        chk("rst_base", 32'(bus.base_tick), 32'd0);
        chk("rst_tick", 32'(bus.tick_o), 32'd0);
        chk("rst_sq",   32'(bus.sq_o), 32'd0);
        chk("rst_pend", 32'(bus.cfg_pend), 32'd0);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            run_to(tbl[k].cyc);
            chk($sformatf("v%0d_base", k), 32'(bus.base_tick), 32'(tbl[k].base));
            chk($sformatf("v%0d_sq", k), 32'(bus.sq_o & tbl[k].sqm), 32'(tbl[k].sq & tbl[k].sqm));
            chk($sformatf("v%0d_pend", k), 32'(bus.cfg_pend), 32'(tbl[k].pend));
            drive(tbl[k].we, tbl[k].sel, tbl[k].per);
            bus.en = tbl[k].en;
        end

        // sync_clr with ch3 pending period 5 and a same-cycle write to ch0.
        run_to(560);
        drive(1'b1, 4'd3, 8'd5);
        run_to(561);
        chk("clr_pre_pend", 32'(bus.cfg_pend), 32'h8);
        drive(1'b0, 4'd0, 8'd0);
        run_to(569);
        sync_clr = 1'b1;
        drive(1'b1, 4'd0, 8'd7);
        run_to(570);
        chk("clr_base", 32'(bus.base_tick), 32'd0);
        chk("clr_tick", 32'(bus.tick_o), 32'd0);
        chk("clr_sq",   32'(bus.sq_o), 32'd0);
        chk("clr_pend", 32'(bus.cfg_pend), 32'd0);
        sync_clr = 1'b0;
        drive(1'b0, 4'd0, 8'd0);
        run_to(571);
        chk("clr_drop_pend", 32'(bus.cfg_pend), 32'd0);
        run_to(579);
        chk("clr_base9", 32'(bus.base_tick), 32'd0);
        run_to(580);
        chk("clr_base10", 32'(bus.base_tick), 32'd1);

        // Asynchronous reset between edges with a write pending.
        run_to(703);
        drive(1'b1, 4'd0, 8'd4);
        run_to(704);
        drive(1'b0, 4'd0, 8'd0);
        chk("arst_pre_pend", 32'(bus.cfg_pend), 32'h1);
        run_to(710);
        chk("arst_pre_base", 32'(bus.base_tick), 32'd1);
        chk("arst_pre_sq2",  32'(bus.sq_o[2]), 32'd1);
        chk_drained("pre_arst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_base", 32'(bus.base_tick), 32'd0);
        chk("arst_tick", 32'(bus.tick_o), 32'd0);
        chk("arst_sq",   32'(bus.sq_o), 32'd0);
        chk("arst_pend", 32'(bus.cfg_pend), 32'd0);
        drive(1'b1, 4'd7, 8'd2);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) exp_q[i].push_back(101);
        run_to(20);
        chk("sel7_pend", 32'(bus.cfg_pend), 32'd0);
        drive(1'b0, 4'd0, 8'd0);
        run_to(120);
        chk("post_pend", 32'(bus.cfg_pend), 32'd0);
        chk_drained("post_arst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
